ysyx_24070014_load_unit: RTL
============================

YSYX_24070014_LOAD_UNIT -- requirements
Module: ysyx_24070014_load_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load request from EXU.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request.
REQ-006 SHALL have port req_addr  input  XLEN  byte address.
REQ-007 SHALL have port req_funct3  input  3  RV32I load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-008 SHALL have port mem_req_valid  output  1  memory read request.
REQ-009 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-010 SHALL have port mem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00}).
REQ-011 SHALL have port mem_rsp_valid  input  1  read data valid (single-cycle pulse; unit is always ready in WAIT).
REQ-012 SHALL have port mem_rdata  input  XLEN  read word.
REQ-013 SHALL have port rsp_valid  output  1  result valid to WBU.
REQ-014 SHALL have port rsp_ready  input  1  WBU accepts result.
REQ-015 SHALL have port rsp_data  output  XLEN  extended load result.
REQ-016 SHALL have port rsp_err  output  1  misaligned address or illegal funct3; qualified by rsp_valid.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, RESP; one request in flight at most.
REQ-018 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready.
REQ-019 SHALL on IDLE handshake register addr[1:0] and funct3, then go to REQ if legal, else to RESP with rsp_err=1.
REQ-020 SHALL treat as illegal: funct3 in {011,110,111}; LH/LHU with addr[0]=1; LW with addr[1:0]!=00.
REQ-021 SHALL on illegal request issue no memory access and drive rsp_data=0.
REQ-022 SHALL in REQ assert mem_req_valid with mem_addr held stable until mem_req_ready; on mem_req_valid && mem_req_ready go to WAIT.
REQ-023 SHALL in WAIT, on mem_rsp_valid, capture the extended result into a register and go to RESP; data arriving in any other state SHALL be ignored.
REQ-024 SHALL select byte mem_rdata[8*addr[1:0]+:8], halfword mem_rdata[16*addr[1]+:16], or full word.
REQ-025 SHALL replicate bit 7 (LB) or bit 15 (LH) into the upper bits; SHALL zero-fill for LBU/LHU.
REQ-026 SHALL in RESP assert rsp_valid, hold rsp_data/rsp_err stable until rsp_ready; on rsp_valid && rsp_ready return to IDLE.
REQ-027 SHALL impose minimum latency: request handshake cycle N -> mem_req_valid in N+1 -> rsp_valid no earlier than cycle after mem_rsp_valid; illegal request -> rsp_valid in N+1.
REQ-028 SHALL NOT accept a new request in the cycle RESP completes (req_ready rises the following cycle).
REQ-029 SHALL drive mem_req_valid, rsp_valid low outside REQ and RESP respectively.

Reset
REQ-030 SHALL, when rst_n=0 at a rising edge, enter IDLE from any state, including mid-transaction; a pending memory response SHALL then be dropped.
REQ-031 SHALL reset outputs: req_ready=1 after reset (IDLE), mem_req_valid=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_addr=0.

Verification
REQ-032 LB addr=0x8000_0003, mem_rdata=0x80FF_1234 -> mem_addr=0x8000_0000, rsp_data=0xFFFF_FF80, rsp_err=0.
REQ-033 LHU addr=0x8000_0002, mem_rdata=0xBEEF_0000 -> rsp_data=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-034 LW addr=0x8000_0001 -> no mem_req_valid, rsp_valid next cycle, rsp_err=1, rsp_data=0.
REQ-035 mem_req_ready low 3 cycles, rsp_ready low 2 cycles -> mem_addr and rsp_data held stable, exactly one transaction each side.
REQ-036 rst_n low during WAIT, mem_rsp_valid pulses after reset -> unit in IDLE, req_ready=1, no rsp_valid.
REQ-037 funct3=011 with addr=0x0 -> rsp_err=1, no memory request.

Source files
------------

// File: rtl/ysyx_24070014_load_unit.sv
// RV32I load unit: one load in flight, word-aligned memory read, then byte/halfword
// selection with sign or zero extension. Misaligned or unknown loads return an error without touching memory.
module ysyx_24070014_load_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      funct3_q, funct3_d;

  logic            illegal;
  logic [7:0]      sel_b;
  logic [15:0]     sel_h;
  logic [XLEN-1:0] load_ext;

  // Decode legality straight from the request so the handshake cycle picks the next state.
  always_comb begin
    unique case (req_funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = req_addr[0];
      3'b010:         illegal = |req_addr[1:0];
      default:        illegal = 1'b1;
    endcase
  end

  always_comb begin
    sel_b = mem_rdata[{off_q, 3'b000} +: 8];
    sel_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
    unique case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){sel_b[7]}}, sel_b};
      3'b001:  load_ext = {{(XLEN-16){sel_h[15]}}, sel_h};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, sel_b};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, sel_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    off_d      = off_q;
    funct3_d   = funct3_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        off_d      = req_addr[1:0];
        funct3_d   = req_funct3;
        rsp_data_d = '0;
        rsp_err_d  = illegal;
        if (illegal) begin
          state_d = S_RESP;
        end else begin
          mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
          state_d    = S_REQ;
        end
      end
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_rsp_valid) begin
        rsp_data_d = load_ext;
        state_d    = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      off_q      <= '0;
      funct3_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign rsp_valid     = (state_q == S_RESP);
  assign mem_addr      = mem_addr_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule
